fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Pipelined instruction fetch unit, the parametrised successor to the single-request fetch stage. It sits between the icache and decode, and keeps up to MAX_OUTSTANDING icache requests in flight. Returned instructions are buffered in an FQ_DEPTH-entry FIFO toward decode. On flush it redirects the PC, clears the FIFO and discards responses from requests issued before the flush, so sequential fetch can sustain one instruction per cycle.

Parameters:
XLEN, 32, PC/address width
FQ_DEPTH, 4, fetch queue entries; power of two, >=2
MAX_OUTSTANDING, 2, max icache requests in flight; >=1
RESET_PC, 32'h0000_0000, PC after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush_i  in  1  redirect request
flush_pc_i  in  XLEN  redirect target
ready_in  in  1  decode accepts head entry
valid_out  out  1  head entry valid
pc_out  out  XLEN  PC of head entry
instr_out  out  32  instruction of head entry
icache_en_o  out  1  request strobe; one request per cycle when high
icache_addr_o  out  XLEN  request address
icache_rdata_i  in  32  response data
icache_rvalid_i  in  1  response valid; responses return in order, >=1 cycle after request
fq_count_o  out  $clog2(FQ_DEPTH+1)  occupied FIFO entries
err_o  out  1  sticky: rvalid seen with nothing outstanding

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- State:
  - issue_pc: next address to request.
  - ret_pc: PC of the next live response.
  - outstanding: total requests in flight, 0..MAX_OUTSTANDING.
  - drop_cnt: stale responses still to be discarded, 0..MAX_OUTSTANDING.
  - FIFO storage with rd/wr pointers and count.
- Reset (rst=1 at the edge):
  - issue_pc=ret_pc=RESET_PC; outstanding=drop_cnt=0.
  - FIFO empty; valid_out=0; fq_count_o=0; err_o=0.
  - pc_out/instr_out read the head slot; their value is don't-care while valid_out=0.
  - Reset overrides every other input, including mid-flight responses.
- Issue (combinational):
  - icache_en_o = !flush_i && (outstanding < MAX_OUTSTANDING) && (outstanding - drop_cnt + count < FQ_DEPTH).
  - icache_addr_o = issue_pc at all times.
  - On issue: issue_pc += 4, mod 2^XLEN (wraps), and outstanding increments.
- Response, when icache_rvalid_i && outstanding>0:
  - outstanding decrements.
  - If drop_cnt>0: drop_cnt decrements and the data is discarded.
  - Else: {ret_pc, icache_rdata_i} is written at the FIFO tail and ret_pc += 4.
  - The issue credit rule guarantees FIFO space. A write into a full FIFO cannot occur and is an assertion failure.
- Spurious response (icache_rvalid_i with outstanding==0): ignored, err_o set to 1 until reset.
- Dequeue:
  - valid_out = (count != 0); pc_out/instr_out = head entry; registered FIFO output, no bypass.
  - valid_out && ready_in pops the head.
  - Push and pop in the same cycle leave count unchanged.
- Latency: request in cycle T, rvalid at T+L, valid_out at T+L+1.
- Throughput: with MAX_OUTSTANDING >= L+1 and ready_in held high, one instruction per cycle at steady state.
- Flush (flush_i=1), highest priority after reset:
  - No issue that cycle.
  - FIFO cleared (count=0, pointers reset); no pop or push takes effect.
  - issue_pc = ret_pc = flush_pc_i.
  - outstanding_next = outstanding - (rvalid && outstanding>0).
  - drop_cnt_next = outstanding_next; a response arriving in the flush cycle is discarded.
  - Fetch resumes the next cycle. Back-to-back flushes: the last one wins.
- Wrap-around: FIFO pointers are log2(FQ_DEPTH) bits with natural wrap. Count is kept separately, so full and empty are unambiguous.
- No combinational path from icache_rvalid_i or ready_in to icache_en_o. Only flush_i feeds it combinationally.

Test Plan:
- Reset to steady stream (L=1, MAX_OUTSTANDING=2, ready_in=1) -> addresses 0,4,8,... on consecutive cycles. valid_out rises 2 cycles after the first request, then delivers PCs 0,4,8 back-to-back with the matching instr.
- Backpressure (ready_in=0 for 10 cycles, FQ_DEPTH=4) -> fq_count_o saturates at 4 and icache_en_o drops to 0. After ready_in=1 there is no loss or duplication and PCs stay sequential.
- Flush with 2 in flight (L=3), flush_pc_i=0x100 -> the next 2 rvalid responses are discarded. First valid_out shows pc_out=0x100, and the first post-flush request address is 0x100.
- Flush in the same cycle as rvalid and ready_in -> that response is dropped, FIFO is empty the next cycle, drop_cnt = outstanding-1.
- Wrap: RESET_PC=0xFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004. FIFO pointer wrap is exercised over 3xFQ_DEPTH entries.
- Spurious rvalid after reset with nothing outstanding -> err_o=1 and stays high, FIFO is unchanged. A later rst=1 clears err_o.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-queue boundary signals: redirect, decode handshake, icache request/response and status.
interface fetch_queue_if #(
   parameter int XLEN     = 32,
   parameter int FQ_DEPTH = 4
);
   logic                            flush_i;
   logic [XLEN-1:0]                 flush_pc_i;
   logic                            ready_in;
   logic                            valid_out;
   logic [XLEN-1:0]                 pc_out;
   logic [31:0]                     instr_out;
   logic                            icache_en_o;
   logic [XLEN-1:0]                 icache_addr_o;
   logic [31:0]                     icache_rdata_i;
   logic                            icache_rvalid_i;
   logic [$clog2(FQ_DEPTH+1)-1:0]   fq_count_o;
   logic                            err_o;

   modport master (
      input  flush_i, flush_pc_i, ready_in, icache_rdata_i, icache_rvalid_i,
      output valid_out, pc_out, instr_out, icache_en_o, icache_addr_o, fq_count_o, err_o
   );

   modport slave (
      output flush_i, flush_pc_i, ready_in, icache_rdata_i, icache_rvalid_i,
      input  valid_out, pc_out, instr_out, icache_en_o, icache_addr_o, fq_count_o, err_o
   );
endinterface

// File: rtl/fetch_queue.sv
// Pipelined fetch: up to MAX_OUTSTANDING icache requests in flight, responses queued toward decode.
// Request at T, response at T+L, valid_out at T+L+1; decode stalls throttle issue through a credit check.
module fetch_queue #(
   parameter int              XLEN            = 32,
   parameter int              FQ_DEPTH        = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst,
   fetch_queue_if.master fq
);
   localparam int PTR_W = $clog2(FQ_DEPTH);
   localparam int CNT_W = $clog2(FQ_DEPTH + 1);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [XLEN-1:0]  issue_pc;
   logic [XLEN-1:0]  ret_pc;
   logic [OUT_W-1:0] outstanding;
   logic [OUT_W-1:0] outstanding_nxt;
   logic [OUT_W-1:0] drop_cnt;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [XLEN-1:0]  pc_mem    [FQ_DEPTH];
   logic [31:0]      instr_mem [FQ_DEPTH];
   logic             err_q;
   logic             issue;
   logic             rsp;
   logic             push;
   logic             pop;

   // Live in-flight requests plus queued entries may never exceed the FIFO, so every
   // accepted response has a slot; stale requests do not reserve space.
   always_comb begin
      issue = !fq.flush_i
              && (int'(outstanding) < MAX_OUTSTANDING)
              && (int'(outstanding) - int'(drop_cnt) + int'(count) < FQ_DEPTH);
      rsp   = fq.icache_rvalid_i && (outstanding != '0);
      push  = rsp && (drop_cnt == '0) && !fq.flush_i;
      pop   = (count != '0) && fq.ready_in && !fq.flush_i;
      outstanding_nxt = outstanding + OUT_W'(issue) - OUT_W'(rsp);
   end

   assign fq.icache_en_o   = issue;
   assign fq.icache_addr_o = issue_pc;
   assign fq.valid_out     = (count != '0);
   assign fq.pc_out        = pc_mem[rd_ptr];
   assign fq.instr_out     = instr_mem[rd_ptr];
   assign fq.fq_count_o    = count;
   assign fq.err_o         = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_pc    <= RESET_PC;
         ret_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         err_q       <= 1'b0;
      end else begin
         outstanding <= outstanding_nxt;
         if (fq.icache_rvalid_i && (outstanding == '0)) begin
            err_q <= 1'b1;
         end
         if (fq.flush_i) begin
            // Everything still in flight after this cycle belongs to the old path.
            issue_pc <= fq.flush_pc_i;
            ret_pc   <= fq.flush_pc_i;
            drop_cnt <= outstanding_nxt;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
         end else begin
            if (issue) begin
               issue_pc <= issue_pc + XLEN'(4);
            end
            if (rsp && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - OUT_W'(1);
            end
            if (push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
               ret_pc <= ret_pc + XLEN'(4);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         assert (count != CNT_W'(FQ_DEPTH));
         pc_mem[wr_ptr]    <= ret_pc;
         instr_mem[wr_ptr] <= fq.icache_rdata_i;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: icache model with programmable latency, expected PCs queued at issue.
module tb_fetch_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_queue_if #(.XLEN(32), .FQ_DEPTH(4)) fq ();
   fetch_queue_if #(.XLEN(32), .FQ_DEPTH(4)) fq2 ();

   fetch_queue #(.XLEN(32), .FQ_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0000))
      dut (.clk(clk), .rst(rst), .fq(fq));
   fetch_queue #(.XLEN(32), .FQ_DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'hFFFF_FFF8))
      dut2 (.clk(clk), .rst(rst), .fq(fq2));

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          lat     = 1;
   logic        spur    = 1'b0;
   logic        model_v = 1'b0;
   logic [31:0] model_d = '0;
   req_t        icq [$];
   logic [31:0] sb  [$];
   logic [31:0] exp_addr = '0;
   int          en_cnt = 0;
   int          pops   = 0;
   int          first_req_cyc = -1;
   int          first_pop_cyc = -1;
   logic        chk_first_req = 1'b0;
   logic        chk_first_pop = 1'b0;
   logic [31:0] first_exp = '0;
   logic        r2v = 1'b0;
   logic [31:0] r2a = '0;
   int          wk = 0;
   logic [31:0] wrap_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'h5A5A_A5A5;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   assign fq.icache_rvalid_i  = model_v | spur;
   assign fq.icache_rdata_i   = model_d;
   assign fq2.flush_i         = 1'b0;
   assign fq2.flush_pc_i      = '0;
   assign fq2.ready_in        = 1'b1;
   assign fq2.icache_rvalid_i = r2v;
   assign fq2.icache_rdata_i  = r2a;

   always @(posedge clk) cyc <= cyc + 1;

   // In-order icache: each request answered no earlier than lat cycles later.
   always @(posedge clk) begin
      #1;
      if (icq.size() != 0 && icq[0].due <= cyc) begin
         model_v = 1'b1;
         model_d = instr_of(icq[0].addr);
         void'(icq.pop_front());
      end else begin
         model_v = 1'b0;
         model_d = '0;
      end
      r2v = r2v;
   end

   // Monitor: pop-and-compare on dequeue, then record new requests into scoreboard and icache.
   always @(negedge clk) begin
      logic [31:0] exp_pc;
      req_t        r;
      if (rst) begin
         icq.delete();
         sb.delete();
         exp_addr = '0;
      end else begin
         if (fq.valid_out && fq.ready_in && !fq.flush_i) begin
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL pop_unexpected: got pc %h expected no entry", fq.pc_out);
            end else begin
               exp_pc = sb.pop_front();
               check("pop_pc", fq.pc_out, exp_pc);
               check("pop_instr", fq.instr_out, instr_of(exp_pc));
               if (chk_first_pop) begin
                  check("first_pop_after_flush", fq.pc_out, first_exp);
                  chk_first_pop = 1'b0;
               end
            end
         end
         if (fq.flush_i) begin
            check("no_issue_in_flush", 32'(fq.icache_en_o), 32'd0);
            sb.delete();
            exp_addr = fq.flush_pc_i;
         end
         if (fq.icache_en_o) begin
            en_cnt++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            check("req_addr", fq.icache_addr_o, exp_addr);
            if (chk_first_req) begin
               check("first_req_after_flush", fq.icache_addr_o, first_exp);
               chk_first_req = 1'b0;
            end
            sb.push_back(exp_addr);
            r.addr = fq.icache_addr_o;
            r.due  = cyc + lat;
            icq.push_back(r);
            exp_addr = exp_addr + 32'd4;
         end
      end
   end

   // Second instance starts at 0xFFFF_FFF8 with a fixed one-cycle icache.
   always @(negedge clk) begin
      if (rst) begin
         r2v <= 1'b0;
      end else begin
         r2v <= fq2.icache_en_o;
         r2a <= fq2.icache_addr_o;
         if (fq2.valid_out && wk < 4) begin
            check("wrap_pc_dut2", fq2.pc_out, wrap_exp[wk]);
            wk++;
         end
      end
   end

   task automatic do_flush(input logic [31:0] pc);
      fq.flush_i    = 1'b1;
      fq.flush_pc_i = pc;
      first_exp     = pc;
      chk_first_req = 1'b1;
      chk_first_pop = 1'b1;
      @(posedge clk);
      #2;
      fq.flush_i = 1'b0;
   endtask

   initial begin
      int exp_drop;
      bit found;
      fq.flush_i    = 1'b0;
      fq.flush_pc_i = '0;
      fq.ready_in   = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid_out", 32'(fq.valid_out), 32'd0);
      check("rst_fq_count", 32'(fq.fq_count_o), 32'd0);
      check("rst_err", 32'(fq.err_o), 32'd0);
      check("rst_addr", fq.icache_addr_o, 32'h0000_0000);
      check("rst_addr_dut2", fq2.icache_addr_o, 32'hFFFF_FFF8);

      // Steady stream, L=1
      @(posedge clk);
      #2;
      rst = 1'b0;
      en_cnt = 0;
      pops = 0;
      first_req_cyc = -1;
      first_pop_cyc = -1;
      repeat (12) @(posedge clk);
      #2;
      check("steady_issue_cycles", en_cnt, 12);
      check("steady_pops", pops, 10);
      check("first_valid_latency", first_pop_cyc - first_req_cyc, 2);

      // Backpressure
      fq.ready_in = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("bp_count_full", 32'(fq.fq_count_o), 32'd4);
      check("bp_issue_stopped", 32'(fq.icache_en_o), 32'd0);
      @(posedge clk);
      #2;
      fq.ready_in = 1'b1;
      repeat (12) @(posedge clk);
      #2;

      // Flush with two stale requests in flight, L=3
      lat = 3;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(posedge clk);
         #2;
         if (icq.size() == 2 && !fq.icache_rvalid_i) found = 1'b1;
      end
      check("wait_two_in_flight", 32'(found), 32'd1);
      do_flush(32'h0000_0100);
      @(negedge clk);
      check("flush_fifo_empty", 32'(fq.fq_count_o), 32'd0);
      check("flush_valid_low", 32'(fq.valid_out), 32'd0);
      check("flush_drop_cnt", 32'(dut.drop_cnt), 32'd2);
      repeat (20) @(posedge clk);
      #2;

      // Flush coinciding with a response and a dequeue
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(posedge clk);
         #2;
         if (fq.icache_rvalid_i && fq.valid_out) found = 1'b1;
      end
      check("wait_rsp_and_pop", 32'(found), 32'd1);
      exp_drop = icq.size();
      do_flush(32'h0000_0200);
      @(negedge clk);
      check("sameflush_fifo_empty", 32'(fq.fq_count_o), 32'd0);
      check("sameflush_drop_cnt", 32'(dut.drop_cnt), 32'(exp_drop));
      repeat (15) @(posedge clk);
      #2;

      // Address wrap and FIFO pointer wrap over more than 3xFQ_DEPTH entries
      lat = 1;
      do_flush(32'hFFFF_FFF8);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #2;
         fq.ready_in = (i % 3 != 0);
      end
      check("wrap_dut2_seen", wk, 4);

      // Spurious response with nothing outstanding and a full FIFO
      fq.ready_in = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(posedge clk);
         #2;
         if (fq.fq_count_o == 3'd4 && icq.size() == 0 && !fq.icache_rvalid_i) found = 1'b1;
      end
      check("wait_idle_full", 32'(found), 32'd1);
      spur = 1'b1;
      @(posedge clk);
      #2;
      spur = 1'b0;
      @(negedge clk);
      check("spur_err_set", 32'(fq.err_o), 32'd1);
      check("spur_fifo_unchanged", 32'(fq.fq_count_o), 32'd4);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("spur_err_sticky", 32'(fq.err_o), 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst2_err_clear", 32'(fq.err_o), 32'd0);
      check("rst2_fq_count", 32'(fq.fq_count_o), 32'd0);
      check("rst2_valid_out", 32'(fq.valid_out), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
